yolo_out_packer: RTL and testbench

Output stage directly downstream of the convolution/maxpool datapath: consumes one signed DATAPATH_W result per handshake, saturates it to ELEM_W, packs PACK results into one memory word and delivers words with an incrementing word address and byte strobes over a valid/ready master port. A small internal FIFO decouples datapath results from memory back-pressure. Each run writes exactly `len` elements, then the block raises `done`.

---
 rtl/yolo_out_packer.sv | 165 ++++++++++++++++
 tb/tb_yolo_out_packer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/yolo_out_packer.sv
// rtl/yolo_out_packer.sv - Saturating result packer with word FIFO and addressed write-out
// Packs saturated datapath results into memory words and streams them out with addresses and strobes.
module yolo_out_packer #(
  parameter int DATAPATH_W = 32,
  parameter int ELEM_W     = 16,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  input  logic [ADDR_W-1:0]          addr_base,
  input  logic [LEN_W-1:0]           len,
  output logic                       done,
  input  logic                       in_valid,
  input  logic [DATAPATH_W-1:0]      in_data,
  output logic                       in_ready,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [ADDR_W-1:0]          m_addr,
  output logic [PACK*ELEM_W-1:0]     m_data,
  output logic [PACK*ELEM_W/8-1:0]   m_strb
);

  localparam int WORD_W = PACK * ELEM_W;
  localparam int STRB_W = WORD_W / 8;
  localparam int BPE    = ELEM_W / 8;
  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W  = PTR_W - 1;

  localparam logic signed [DATAPATH_W-1:0] SAT_MAX = {{(DATAPATH_W-ELEM_W+1){1'b0}}, {(ELEM_W-1){1'b1}}};
  localparam logic signed [DATAPATH_W-1:0] SAT_MIN = {{(DATAPATH_W-ELEM_W+1){1'b1}}, {(ELEM_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [WORD_W-1:0]   pack_q, pack_d;
  logic                done_q, done_d;
  logic [PTR_W-1:0]    wr_q, wr_d, rd_q, rd_d;

  logic [WORD_W-1:0]   fifo_data [FIFO_DEPTH];
  logic [STRB_W-1:0]   fifo_strb [FIFO_DEPTH];

  logic [PTR_W-1:0]    fifo_cnt;
  logic                fifo_empty;
  logic                accept, last_elem, push, pop, drain_done;
  logic [ELEM_W-1:0]   sat_elem;
  logic [WORD_W-1:0]   pack_word;
  logic [STRB_W-1:0]   strb_word;

  assign fifo_cnt   = wr_q - rd_q;
  assign fifo_empty = (fifo_cnt == '0);
  assign accept     = in_valid && in_ready;
  assign last_elem  = (rem_q == LEN_W'(1));
  assign push       = accept && ((lane_q == LANE_W'(PACK - 1)) || last_elem);
  assign pop        = m_valid && m_ready;
  assign drain_done = fifo_empty || ((fifo_cnt == PTR_W'(1)) && pop);

  assign sat_elem = ($signed(in_data) > SAT_MAX) ? SAT_MAX[ELEM_W-1:0] :
                    ($signed(in_data) < SAT_MIN) ? SAT_MIN[ELEM_W-1:0] :
                    in_data[ELEM_W-1:0];

  // The word pushed includes the element accepted this cycle; unfilled lanes stay zero.
  always_comb begin
    pack_word = pack_q;
    pack_word[int'(lane_q)*ELEM_W +: ELEM_W] = sat_elem;
    strb_word = '0;
    for (int i = 0; i < PACK; i++) begin
      if (i <= int'(lane_q)) strb_word[i*BPE +: BPE] = {BPE{1'b1}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (run) state_d = (len == '0) ? S_DRAIN : S_RUN;
      S_RUN:   if (push && last_elem) state_d = S_DRAIN;
      S_DRAIN: if (drain_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_RUN) && (fifo_cnt < PTR_W'(FIFO_DEPTH));
  end

  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    lane_d = lane_q;
    pack_d = pack_q;
    done_d = done_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    if ((state_q == S_IDLE) && run) begin
      addr_d = addr_base;
      rem_d  = len;
      lane_d = '0;
      pack_d = '0;
      done_d = 1'b0;
    end
    if (accept) begin
      rem_d = rem_q - LEN_W'(1);
      if (push) begin
        lane_d = '0;
        pack_d = '0;
        wr_d   = wr_q + PTR_W'(1);
      end else begin
        lane_d = lane_q + LANE_W'(1);
        pack_d = pack_word;
      end
    end
    if (pop) begin
      rd_d   = rd_q + PTR_W'(1);
      addr_d = addr_q + ADDR_W'(1);
    end
    if ((state_q == S_DRAIN) && drain_done) done_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      rem_q  <= '0;
      lane_q <= '0;
      pack_q <= '0;
      done_q <= 1'b0;
      wr_q   <= '0;
      rd_q   <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
      lane_q <= lane_d;
      pack_q <= pack_d;
      done_q <= done_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_q[IDX_W-1:0]] <= pack_word;
      fifo_strb[wr_q[IDX_W-1:0]] <= strb_word;
    end
  end

  assign done    = done_q;
  assign m_valid = !fifo_empty;
  assign m_addr  = addr_q;
  assign m_data  = fifo_empty ? '0 : fifo_data[rd_q[IDX_W-1:0]];
  assign m_strb  = fifo_empty ? '0 : fifo_strb[rd_q[IDX_W-1:0]];

endmodule

// File: tb/tb_yolo_out_packer.sv
// tb/tb_yolo_out_packer.sv - Scoreboard bench for yolo_out_packer
module tb_yolo_out_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [31:0] addr_base;
  logic [15:0] len;
  logic        done;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_addr;
  logic [63:0] m_data;
  logic [7:0]  m_strb;

  yolo_out_packer dut (
    .clk(clk), .rst(rst), .run(run), .addr_base(addr_base), .len(len), .done(done),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data), .m_strb(m_strb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } word_t;

  word_t exp_q[$];
  int    elems[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  int    last_pop_cyc = -1;
  int    accepted = 0;
  int    mr_mode  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] sat16(input int x);
    if (x > 32767)       return 16'h7fff;
    else if (x < -32768) return 16'h8000;
    else                 return x[15:0];
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (mr_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      check("word_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        word_t w;
        w = exp_q.pop_front();
        check("m_addr", 64'(m_addr), 64'(w.addr));
        check("m_data", m_data, w.data);
        check("m_strb", 64'(m_strb), 64'(w.strb));
      end
      last_pop_cyc = cyc;
    end
  end

  // Reference: group elements four per word, lane 0 lowest, addresses counting up from base.
  task automatic start_run(input logic [31:0] base, input int n);
    for (int w = 0; w < (n + 3) / 4; w++) begin
      word_t e;
      e.addr = base + 32'(w);
      e.data = '0;
      e.strb = '0;
      for (int l = 0; l < 4; l++) begin
        if (w * 4 + l < n) begin
          e.data = e.data | (64'(sat16(elems[w * 4 + l])) << (16 * l));
          e.strb = e.strb | (8'h03 << (2 * l));
        end
      end
      exp_q.push_back(e);
    end
    run = 1'b1; addr_base = base; len = 16'(n);
    @(posedge clk); #1;
    run = 1'b0;
  endtask

  task automatic feed(input int first, input int n, input bit gaps);
    for (int i = first; i < first + n; i++) begin
      int budget;
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = elems[i];
      budget   = 0;
      @(negedge clk);
      while (!in_ready && budget < 500) begin
        @(negedge clk);
        budget++;
      end
      if (!in_ready) begin
        check("in_ready_timeout", 64'(in_ready), 64'd1);
        break;
      end
      @(posedge clk); #1;
      accepted++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int budget = 0;
    @(negedge clk);
    while (!done && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    check("done_seen", 64'(done), 64'd1);
    check("done_latency", 64'(cyc), 64'(last_pop_cyc + 1));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; run = 1'b0; addr_base = '0; len = '0; in_valid = 1'b0; in_data = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_done", 64'(done), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_addr", 64'(m_addr), 64'd0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_m_strb", 64'(m_strb), 64'd0);
    @(posedge clk); #1;

    // Two full words from a simple ramp
    mr_mode = 1;
    elems = {};
    for (int i = 1; i <= 8; i++) elems.push_back(i);
    start_run(32'h100, 8);
    feed(0, 8, 1'b0);
    wait_done();

    // Partial final word
    elems = {10, 11, 12, 13, 14};
    start_run(32'h100, 5);
    feed(0, 5, 1'b0);
    wait_done();

    // Saturation corners
    elems = {32'h0001_2345, 32'hFFFF_0000, 32'h0000_7FFF, -1};
    start_run(32'h40, 4);
    feed(0, 4, 1'b0);
    wait_done();

    // Back-pressure: the FIFO holds 16 elements before in_ready drops
    mr_mode = 0;
    elems = {};
    for (int i = 1; i <= 32; i++) elems.push_back(i * 3 - 50);
    accepted = 0;
    start_run(32'h180, 32);
    fork
      feed(0, 32, 1'b0);
      begin
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("bp_accepted", 64'(accepted), 64'd16);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_m_valid", 64'(m_valid), 64'd1);
        mr_mode = 1;
      end
    join
    wait_done();

    // len=0 completes two cycles after run without issuing words
    run = 1'b1; addr_base = 32'h900; len = 16'd0;
    @(posedge clk); #1;
    run = 1'b0;
    @(negedge clk);
    check("len0_done_t1", 64'(done), 64'd0);
    check("len0_m_valid_t1", 64'(m_valid), 64'd0);
    @(negedge clk);
    check("len0_done_t2", 64'(done), 64'd1);
    check("len0_m_valid_t2", 64'(m_valid), 64'd0);
    @(posedge clk); #1;

    // run while running is ignored
    elems = {100, -200, 300, -400};
    start_run(32'h400, 4);
    feed(0, 2, 1'b0);
    run = 1'b1; addr_base = 32'h500; len = 16'd8;
    @(posedge clk); #1;
    run = 1'b0;
    feed(2, 2, 1'b0);
    wait_done();
    repeat (3) @(negedge clk);
    check("ignored_run_idle", 64'(m_valid), 64'd0);
    check("ignored_run_done", 64'(done), 64'd1);
    @(posedge clk); #1;

    // Reset with two words queued
    mr_mode = 0;
    elems = {};
    for (int i = 0; i < 16; i++) elems.push_back(int'($urandom));
    start_run(32'h200, 16);
    feed(0, 8, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_m_valid", 64'(m_valid), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    mr_mode = 1;
    elems = {7, 8, 9, 70000};
    start_run(32'h300, 4);
    feed(0, 4, 1'b0);
    wait_done();

    // Random runs with gaps and random back-pressure
    mr_mode = 2;
    for (int r = 0; r < 8; r++) begin
      int n;
      logic [31:0] base;
      n = $urandom_range(1, 20);
      base = (r == 7) ? 32'hFFFF_FFFE : $urandom;
      elems = {};
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) elems.push_back(int'($urandom));
        else elems.push_back($urandom_range(0, 80000) - 40000);
      end
      start_run(base, n);
      feed(0, n, 1'b1);
      wait_done();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
